// File: rtl/team_04_gpio_io_stage_if.sv
// Pad/core signal bundle for the team 04 GPIO I/O stage.
// No valid/ready handshake: every signal is a level that is sampled on each rising clk edge.
interface team_04_gpio_io_stage_if #(
  parameter int NUM_IO = 34
);
  logic              en;
  logic [NUM_IO-1:0] gpio_in;
  logic [NUM_IO-1:0] gpio_in_db;
  logic [NUM_IO-1:0] core_out;
  logic [NUM_IO-1:0] core_oeb;
  logic [NUM_IO-1:0] gpio_out;
  logic [NUM_IO-1:0] gpio_oeb;
  logic              ready;

  modport master (
    output en, gpio_in, core_out, core_oeb,
    input  gpio_in_db, gpio_out, gpio_oeb, ready
  );

  modport slave (
    input  en, gpio_in, core_out, core_oeb,
    output gpio_in_db, gpio_out, gpio_oeb, ready
  );
endinterface

// File: rtl/team_04_gpio_io_stage.sv
// Pad-side GPIO stage: synchronise/debounce inputs, drive a ready signature, then pass core outputs to pads.
// Optional pad loopback self-test is compiled in with macro TEAM_04_GPIO_LOOPBACK_EN.
module team_04_gpio_io_stage #(
  parameter int                NUM_IO          = 34,
  parameter int                DEBOUNCE_CYCLES = 4,
  parameter int                SIG_CYCLES      = 8,
  parameter logic [NUM_IO-1:0] SIGNATURE       = 34'h2_5A5A_5A5A
) (
  input  logic                           clk,
  input  logic                           nrst,
`ifdef TEAM_04_GPIO_LOOPBACK_EN
  input  logic                           loopback,
`endif
  team_04_gpio_io_stage_if.slave         io,
  output logic [1:0]                     state_dbg
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = (SIG_CYCLES > 1) ? $clog2(SIG_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SIG_LAST = SW'(SIG_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SIG  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  logic [NUM_IO-1:0] sync1;
  logic [NUM_IO-1:0] sync2;
  logic [NUM_IO-1:0] db_q;
  logic [CW-1:0]     cnt [NUM_IO];

  state_t            state;
  state_t            state_next;
  logic [SW-1:0]     sig_cnt;
  logic [SW-1:0]     sig_cnt_next;

  logic [NUM_IO-1:0] out_q;
  logic [NUM_IO-1:0] oeb_q;
  logic              ready_q;
  logic [NUM_IO-1:0] out_next;
  logic [NUM_IO-1:0] oeb_next;
  logic              ready_next;

  // Input path runs regardless of FSM state.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= io.gpio_in;
      sync2 <= sync1;
    end
  end

  // A bit is accepted only after DEBOUNCE_CYCLES consecutive cycles disagreeing with the held value.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      db_q <= '0;
      for (int i = 0; i < NUM_IO; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_IO; i++) begin
        if (sync2[i] == db_q[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          db_q[i] <= sync2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= ST_IDLE;
      sig_cnt <= '0;
      out_q   <= '0;
      oeb_q   <= '1;
      ready_q <= 1'b0;
    end else begin
      state   <= state_next;
      sig_cnt <= sig_cnt_next;
      out_q   <= out_next;
      oeb_q   <= oeb_next;
      ready_q <= ready_next;
    end
  end

  // Dropping en wins over signature completion and always restarts the signature.
  always_comb begin
    state_next   = state;
    sig_cnt_next = sig_cnt;
    case (state)
      ST_IDLE: begin
        sig_cnt_next = '0;
        state_next   = ST_SIG;
      end
      ST_SIG: begin
        if (sig_cnt == SIG_LAST) state_next = ST_RUN;
        else                     sig_cnt_next = sig_cnt + SW'(1);
      end
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_IDLE;
    endcase
    if (!io.en) begin
      state_next   = ST_IDLE;
      sig_cnt_next = '0;
    end
  end

  always_comb begin
    out_next   = '0;
    oeb_next   = '1;
    ready_next = 1'b0;
    if (io.en) begin
      case (state)
        ST_SIG: begin
          out_next = SIGNATURE;
          oeb_next = '0;
        end
        ST_RUN: begin
          ready_next = 1'b1;
          out_next   = io.core_out;
          oeb_next   = io.core_oeb;
`ifdef TEAM_04_GPIO_LOOPBACK_EN
          if (loopback) begin
            out_next = db_q;
            oeb_next = ~io.core_oeb;
          end
`endif
        end
        default: begin
          out_next = '0;
          oeb_next = '1;
        end
      endcase
    end
  end

  assign io.gpio_in_db = db_q;
  assign io.gpio_out   = out_q;
  assign io.gpio_oeb   = oeb_q;
  assign io.ready      = ready_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_team_04_gpio_io_stage.sv
// Bench for team_04_gpio_io_stage: directed and random stimulus, per-cycle scoreboard against a sequence-level model.
module tb_team_04_gpio_io_stage;
  localparam int NUM_IO = 34;
  localparam int DEB    = 4;
  localparam int SIGC   = 8;
  localparam logic [NUM_IO-1:0] SIGN = 34'h2_5A5A_5A5A;
  localparam int W      = 3 * NUM_IO + 1;
  localparam int HW     = DEB + 2;

  logic clk;
  logic nrst;
  logic [1:0] state_dbg;
`ifdef TEAM_04_GPIO_LOOPBACK_EN
  logic loopback;
`endif

  team_04_gpio_io_stage_if #(.NUM_IO(NUM_IO)) io ();

  team_04_gpio_io_stage dut (
    .clk       (clk),
    .nrst      (nrst),
`ifdef TEAM_04_GPIO_LOOPBACK_EN
    .loopback  (loopback),
`endif
    .io        (io),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected pad behaviour from the en-high run length; debounced value from the raw pad history.
  int                en_run;
  logic [NUM_IO-1:0] m_db;
  logic [NUM_IO-1:0] hist [HW];

  always @(posedge clk) begin
    logic [NUM_IO-1:0] db_before;
    logic [NUM_IO-1:0] e_out;
    logic [NUM_IO-1:0] e_oeb;
    logic              e_rdy;
    logic              flip;
    if (!nrst) begin
      en_run = 0;
      m_db   = '0;
      for (int k = 0; k < HW; k++) hist[k] = '0;
      exp_q.delete();
    end else begin
      db_before = m_db;
      for (int k = HW - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = io.gpio_in;
      for (int i = 0; i < NUM_IO; i++) begin
        flip = 1'b1;
        for (int k = 2; k < HW; k++) if (hist[k][i] == m_db[i]) flip = 1'b0;
        if (flip) m_db[i] = ~m_db[i];
      end
      en_run = io.en ? ((en_run < SIGC + 2) ? en_run + 1 : en_run) : 0;
      if (en_run <= 1) begin
        e_out = '0; e_oeb = '1; e_rdy = 1'b0;
      end else if (en_run <= SIGC + 1) begin
        e_out = SIGN; e_oeb = '0; e_rdy = 1'b0;
      end else begin
        e_out = io.core_out; e_oeb = io.core_oeb; e_rdy = 1'b1;
`ifdef TEAM_04_GPIO_LOOPBACK_EN
        if (loopback) begin
          e_out = db_before;
          e_oeb = ~io.core_oeb;
        end
`endif
      end
      exp_q.push_back({e_out, e_oeb, e_rdy, m_db});
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    logic [W-1:0] e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("gpio_out",   64'(io.gpio_out),   64'(e[W-1 -: NUM_IO]));
      chk("gpio_oeb",   64'(io.gpio_oeb),   64'(e[2*NUM_IO : NUM_IO+1]));
      chk("ready",      64'(io.ready),      64'(e[NUM_IO]));
      chk("gpio_in_db", 64'(io.gpio_in_db), 64'(e[NUM_IO-1:0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #5;
    end
  endtask

  task automatic check_after_edge(input string name, input logic act_sel, input logic exp);
    @(posedge clk);
    #2;
    chk(name, 64'(act_sel ? io.gpio_in_db[3] : io.ready), 64'(exp));
    #3;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_out"},  64'(io.gpio_out),   64'h0);
    chk({tag, "_oeb"},  64'(io.gpio_oeb),   64'h3_FFFF_FFFF);
    chk({tag, "_rdy"},  64'(io.ready),      64'h0);
    chk({tag, "_db"},   64'(io.gpio_in_db), 64'h0);
  endtask

  task automatic random_phase(input int n);
    logic [63:0] r;
    repeat (n) begin
      r = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      io.gpio_in  = io.gpio_in ^ r[NUM_IO-1:0];
      r = {$urandom, $urandom};
      io.core_out = r[NUM_IO-1:0];
      r = {$urandom, $urandom};
      io.core_oeb = r[NUM_IO-1:0];
      if ($urandom_range(0, 29) == 0) io.en = ~io.en;
`ifdef TEAM_04_GPIO_LOOPBACK_EN
      if ($urandom_range(0, 7) == 0) loopback = ~loopback;
`endif
      step(1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    nrst        = 1'b0;
    io.en       = 1'b0;
    io.gpio_in  = '0;
    io.core_out = '0;
    io.core_oeb = '0;
`ifdef TEAM_04_GPIO_LOOPBACK_EN
    loopback    = 1'b0;
`endif
    step(3);
    check_reset_values("reset_hold");
    nrst = 1'b1;
    step(100);

    // Enable with fixed core data: signature then core value.
    io.core_out = 34'h0_1234_5678;
    io.core_oeb = '0;
    io.en       = 1'b1;
    step(12);

    // Glitch of 3 clocks never reaches the core.
    io.gpio_in[3] = 1'b1;
    step(3);
    io.gpio_in[3] = 1'b0;
    for (int i = 0; i < 8; i++) check_after_edge("glitch_db3", 1'b1, 1'b0);

    // Clean edge appears exactly 2+DEB clocks later.
    io.gpio_in[3] = 1'b1;
    for (int i = 0; i < 5; i++) check_after_edge("latency_db3_early", 1'b1, 1'b0);
    check_after_edge("latency_db3_edge", 1'b1, 1'b1);

    // Drop en during the 4th signature cycle, then replay.
    io.en = 1'b0;
    step(3);
    io.en = 1'b1;
    step(5);
    io.en = 1'b0;
    step(3);
    io.en = 1'b1;
    step(14);

    random_phase(500);

    // Asynchronous reset mid-RUN.
    io.en = 1'b1;
    step(12);
    check_after_edge("run_ready", 1'b0, 1'b1);
    nrst = 1'b0;
    #1;
    check_reset_values("async_reset");
    step(2);
    nrst = 1'b1;
    step(20);

    random_phase(300);
    step(2);
    chk("scoreboard_drained", 64'(exp_q.size() > 1), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
